// File: rtl/render_feeder_pkg.sv
// rtl/render_feeder_pkg.sv - shared states, register map and status bit positions for the render queue feeder
package render_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_KICK  = 2'd2,
    ST_WAIT  = 2'd3
  } feeder_state_t;

  // Write register map
  localparam logic [2:0] ADDR_PUSH    = 3'd0;
  localparam logic [2:0] ADDR_COMMIT  = 3'd1;
  localparam logic [2:0] ADDR_CLEAR   = 3'd2;
  localparam logic [2:0] ADDR_IRQ_ACK = 3'd3;

  // Read register map
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_COUNT   = 3'd1;

  // Status register bit positions
  localparam int STAT_EMPTY    = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_BUSY     = 2;
  localparam int STAT_OVERFLOW = 3;
  localparam int STAT_REJECT   = 4;
  localparam int STAT_TIMEOUT  = 5;
  localparam int STAT_IRQ      = 6;

endpackage

// File: rtl/render_byte_fifo.sv
// rtl/render_byte_fifo.sv - synchronous 8-bit staging FIFO with occupancy count
module render_byte_fifo #(
  parameter int DEPTH = 25
) (
  input  logic                       clk50,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // A push into a full FIFO is allowed only when a pop frees the slot the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk50) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
  always_ff @(posedge clk50) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/render_queue_feeder.sv
// rtl/render_queue_feeder.sv - Avalon-MM staged feeder into the vga_display render queue (option: RENDER_FEEDER_IRQ_EN)
module render_queue_feeder
  import render_feeder_pkg::*;
#(
  parameter int DEPTH          = 25,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       chipselect,
  input  logic       write,
  input  logic       read,
  input  logic [2:0] address,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       render_queue_we,
  output logic [7:0] render_queue_din,
  output logic       do_render,
  input  logic       done_rendering,
  output logic       irq
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  feeder_state_t state;
  logic [TW-1:0] timer;
  logic          overflow;
  logic          reject;
  logic          timeout;

  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic          wr_en;
  logic          push_req;
  logic          commit_req;
  logic          clear_req;
  logic          idle;
  logic          commit_go;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_clear;
  logic [7:0]    status;

  assign wr_en      = chipselect && write;
  assign push_req   = wr_en && (address == ADDR_PUSH);
  assign commit_req = wr_en && (address == ADDR_COMMIT);
  assign clear_req  = wr_en && (address == ADDR_CLEAR);
  assign idle       = (state == ST_IDLE);

  assign commit_go  = idle && commit_req && (fifo_count != '0);
  assign fifo_push  = idle && push_req && !fifo_full;
  // The head byte leaves the FIFO as it is registered onto render_queue_din.
  assign fifo_pop   = commit_go || ((state == ST_DRAIN) && !fifo_empty);
  assign fifo_clear = idle && clear_req;

  render_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk50     (clk50),
    .reset     (reset),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (writedata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef RENDER_FEEDER_IRQ_EN
  logic irq_flag;
  logic ack_req;

  assign ack_req = wr_en && (address == ADDR_IRQ_ACK);
  assign irq     = irq_flag;

  // Completion interrupt: set on a done-terminated render, held until acknowledged.
  always_ff @(posedge clk50) begin
    if (reset) begin
      irq_flag <= 1'b0;
    end else if ((state == ST_WAIT) && done_rendering) begin
      irq_flag <= 1'b1;
    end else if (ack_req) begin
      irq_flag <= 1'b0;
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read data is combinational so the CPU sees it with zero wait states.
  always_comb begin
    status                = 8'h00;
    status[STAT_EMPTY]    = fifo_empty;
    status[STAT_FULL]     = fifo_full;
    status[STAT_BUSY]     = !idle;
    status[STAT_OVERFLOW] = overflow;
    status[STAT_REJECT]   = reject;
    status[STAT_TIMEOUT]  = timeout;
    status[STAT_IRQ]      = irq;
    readdata              = 8'h00;
    if (chipselect && read) begin
      case (address)
        ADDR_STATUS: readdata = status;
        ADDR_COUNT:  readdata = 8'(fifo_count);
        default:     readdata = 8'h00;
      endcase
    end
  end

  // Main sequencer: drain staged bytes, kick the renderer, then wait for done or timeout.
  always_ff @(posedge clk50) begin
    if (reset) begin
      state            <= ST_IDLE;
      timer            <= '0;
      overflow         <= 1'b0;
      reject           <= 1'b0;
      timeout          <= 1'b0;
      render_queue_we  <= 1'b0;
      render_queue_din <= 8'h00;
      do_render        <= 1'b0;
    end else begin
      render_queue_we  <= 1'b0;
      render_queue_din <= 8'h00;
      do_render        <= 1'b0;
      if (clear_req) begin
        overflow <= 1'b0;
        reject   <= 1'b0;
        timeout  <= 1'b0;
      end
      if (push_req && !idle) reject <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (push_req && fifo_full) overflow <= 1'b1;
          if (commit_go) begin
            render_queue_we  <= 1'b1;
            render_queue_din <= fifo_head;
            state            <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!fifo_empty) begin
            render_queue_we  <= 1'b1;
            render_queue_din <= fifo_head;
          end else begin
            do_render <= 1'b1;
            state     <= ST_KICK;
          end
        end
        ST_KICK: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_rendering) begin
            state <= ST_IDLE;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_render_queue_feeder.sv
// tb/tb_render_queue_feeder.sv - directed self-checking bench for render_queue_feeder
module tb_render_queue_feeder;

`ifdef RENDER_FEEDER_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif
  localparam logic [7:0] IRQ_BIT = IRQ_ON ? 8'h40 : 8'h00;

  logic       clk50 = 1'b0;
  logic       reset;
  logic       chipselect;
  logic       write;
  logic       read;
  logic [2:0] address;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       render_queue_we;
  logic [7:0] render_queue_din;
  logic       do_render;
  logic       done_rendering;
  logic       irq;

  int tests_run    = 0;
  int tests_failed = 0;

  render_queue_feeder #(.DEPTH(25), .TIMEOUT_CYCLES(16)) dut (
    .clk50            (clk50),
    .reset            (reset),
    .chipselect       (chipselect),
    .write            (write),
    .read             (read),
    .address          (address),
    .writedata        (writedata),
    .readdata         (readdata),
    .render_queue_we  (render_queue_we),
    .render_queue_din (render_queue_din),
    .do_render        (do_render),
    .done_rendering   (done_rendering),
    .irq              (irq)
  );

  always #10 clk50 = ~clk50;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk50);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    @(negedge clk50);
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    #1;
    d          = readdata;
    chipselect = 1'b0;
    read       = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk50);
    done_rendering = 1'b1;
    @(negedge clk50);
    done_rendering = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic [7:0] exp_b [3];
    int         idx;
    int         cnt;
    logic       seen;

    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = 3'd0; writedata = 8'h00; done_rendering = 1'b0;

    // 1: reset state
    repeat (3) @(negedge clk50);
    check_val("rst_we", render_queue_we, 0);
    check_val("rst_din", render_queue_din, 0);
    check_val("rst_do_render", do_render, 0);
    check_val("rst_irq", irq, 0);
    check_val("rst_readdata_idle", readdata, 0);
    reset = 1'b0;
    @(negedge clk50);
    bus_read(3'd0, rd); check_val("rst_status", rd, 8'h01);
    bus_read(3'd1, rd); check_val("rst_count", rd, 0);

    // 2: three-byte render with done
    bus_write(3'd0, 8'h11);
    bus_write(3'd0, 8'h22);
    bus_write(3'd0, 8'h33);
    bus_read(3'd1, rd); check_val("t2_count3", rd, 3);
    bus_write(3'd1, 8'h00);
    for (int k = 0; k < 3; k++) begin
      check_val("t2_we", render_queue_we, 1);
      check_val("t2_din", render_queue_din, exp_b[k]);
      check_val("t2_no_kick_yet", do_render, 0);
      @(negedge clk50);
    end
    check_val("t2_we_end", render_queue_we, 0);
    check_val("t2_kick", do_render, 1);
    @(negedge clk50);
    check_val("t2_kick_one_cycle", do_render, 0);
    bus_read(3'd0, rd); check_val("t2_status_wait", rd, 8'h05);
    repeat (3) @(negedge clk50);
    bus_read(3'd0, rd); check_val("t2_status_still_wait", rd, 8'h05);
    pulse_done();
    bus_read(3'd0, rd); check_val("t2_status_done", rd, 8'h01 | IRQ_BIT);
    bus_read(3'd1, rd); check_val("t2_count_done", rd, 0);
    check_val("t2_irq", irq, IRQ_ON);
    bus_write(3'd3, 8'h00);
    check_val("t2_irq_ack", irq, 0);
    bus_read(3'd0, rd); check_val("t2_status_ack", rd, 8'h01);

    // 3: overflow at DEPTH, 26th byte never emitted
    for (int i = 0; i < 26; i++) bus_write(3'd0, (i < 25) ? 8'(i + 1) : 8'hEE);
    bus_read(3'd1, rd); check_val("t3_count", rd, 25);
    bus_read(3'd0, rd); check_val("t3_status", rd, 8'h0A);
    bus_write(3'd1, 8'h00);
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      if (do_render) break;
      if (render_queue_we) begin
        check_val("t3_din", render_queue_din, idx + 1);
        idx++;
      end
      @(negedge clk50);
    end
    check_val("t3_bytes", idx, 25);
    check_val("t3_kick", do_render, 1);
    pulse_done();
    bus_write(3'd2, 8'h00);
    bus_read(3'd0, rd); check_val("t3_status_clear", rd, 8'h01 | IRQ_BIT);
    bus_write(3'd3, 8'h00);

    // 4: commit on empty FIFO
    bus_write(3'd1, 8'h00);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      seen = seen | render_queue_we | do_render;
      bus_read(3'd0, rd);
      seen = seen | rd[2];
      @(negedge clk50);
    end
    check_val("t4_no_activity", seen, 0);
    bus_read(3'd0, rd); check_val("t4_status", rd, 8'h01);

    // 5: timeout after 16 WAIT cycles, push during WAIT rejected
    bus_write(3'd0, 8'h5A);
    bus_write(3'd1, 8'h00);
    for (int c = 0; c < 10; c++) begin
      if (do_render) break;
      @(negedge clk50);
    end
    check_val("t5_kick", do_render, 1);
    bus_write(3'd0, 8'h77);
    cnt = 1;
    for (int c = 0; c < 40; c++) begin
      bus_read(3'd0, rd);
      if (!rd[2]) break;
      cnt++;
      @(negedge clk50);
    end
    check_val("t5_wait_cycles", cnt, 16);
    bus_read(3'd0, rd); check_val("t5_status", rd, 8'h31);
    check_val("t5_irq", irq, 0);
    bus_write(3'd2, 8'h00);
    bus_read(3'd0, rd); check_val("t5_status_clear", rd, 8'h01);

    // 6: reset in the middle of DRAIN
    for (int i = 0; i < 5; i++) bus_write(3'd0, 8'(8'hA0 + i));
    bus_write(3'd1, 8'h00);
    check_val("t6_draining", render_queue_we, 1);
    reset = 1'b1;
    @(negedge clk50);
    check_val("t6_we_low", render_queue_we, 0);
    check_val("t6_kick_low", do_render, 0);
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      seen = seen | render_queue_we | do_render;
      @(negedge clk50);
    end
    check_val("t6_no_activity", seen, 0);
    bus_read(3'd1, rd); check_val("t6_count", rd, 0);
    bus_read(3'd0, rd); check_val("t6_status", rd, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
